// File: rtl/int_claim_arbiter_pkg.sv
// Shared state encoding and sizing helper for the interrupt claim arbiter.
package int_claim_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ARB, OFFER, SERVICE} arb_state_t;

  // Source IDs run 1..num_src with 0 reserved for "none".
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/int_claim_prio_tree.sv
// Combinational winner select: highest priority among eligible sources,
// lowest ID on a tie; win_id is 0 when nothing is eligible.
module int_claim_prio_tree
  import int_claim_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W = 2,
  localparam int ID_W = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]             eligible,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]                win_id
);

  logic [PRIO_W-1:0] best_prio;

  // Ascending scan with a strict compare keeps the lowest ID on ties.
  always_comb begin
    win_id = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && ((win_id == '0) || (prio[i] > best_prio))) begin
        win_id = ID_W'(i + 1);
        best_prio = prio[i];
      end
    end
  end

endmodule

// File: rtl/int_claim_arbiter.sv
// Interrupt scheduler with claim/complete handshake in front of the core.
// Define INT_CLAIM_ARBITER_EDGE_EN for rising-edge pending capture.
module int_claim_arbiter
  import int_claim_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W = 2,
  localparam int ID_W = id_width(NUM_SRC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic              cfg_we,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic              cfg_en,
  input  logic [PRIO_W-1:0] cfg_prio,
  input  logic [PRIO_W-1:0] threshold,
  output logic              irq_req,
  input  logic              claim,
  output logic [ID_W-1:0]   claim_id,
  input  logic              complete,
  input  logic [ID_W-1:0]   complete_id,
  output logic              err
);

  arb_state_t state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pending_set;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] cfg_mask;
  logic [ID_W-1:0]    win_id;
  logic               claim_take;

  // One-hot decode of an ID; 0 and out-of-range IDs give an empty mask.
  function automatic logic [NUM_SRC-1:0] id_mask(input logic [ID_W-1:0] id);
    id_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id == ID_W'(i + 1)) id_mask[i] = 1'b1;
    end
  endfunction

  assign claim_mask = id_mask(claim_id);
  assign cfg_mask   = id_mask(cfg_id);
  assign claim_take = (state == OFFER) && claim;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] & en[i] & (prio[i] > threshold);
    end
  end

`ifdef INT_CLAIM_ARBITER_EDGE_EN
  logic [NUM_SRC-1:0] irq_prev;

  always_ff @(posedge clock) begin
    if (!reset) irq_prev <= '0;
    else        irq_prev <= irq_in;
  end

  // Edges are latched even while in service so they are not lost.
  assign pending_set = irq_in & ~irq_prev;
`else
  assign pending_set = irq_in & ~in_service;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending <= '0;
      en      <= '0;
      prio    <= '0;
    end else begin
      pending <= (pending | pending_set) & ~(claim_take ? claim_mask : '0);
      if (cfg_we) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (cfg_mask[i]) begin
            en[i]   <= cfg_en;
            prio[i] <= cfg_prio;
          end
        end
      end
    end
  end

  int_claim_prio_tree #(
    .NUM_SRC(NUM_SRC),
    .PRIO_W (PRIO_W)
  ) u_prio_tree (
    .eligible(eligible),
    .prio    (prio),
    .win_id  (win_id)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      claim_id   <= '0;
      in_service <= '0;
      err        <= 1'b0;
    end else begin
      if (claim && (state != OFFER)) err <= 1'b1;
      if (complete && (state != SERVICE)) err <= 1'b1;
      case (state)
        IDLE: begin
          if (|eligible) state <= ARB;
        end
        ARB: begin
          if (win_id != '0) begin
            claim_id <= win_id;
            irq_req  <= 1'b1;
            state    <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        OFFER: begin
          if (claim) begin
            in_service <= in_service | claim_mask;
            irq_req    <= 1'b0;
            state      <= SERVICE;
          end else if (!(|(eligible & claim_mask))) begin
            claim_id <= '0;
            irq_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        SERVICE: begin
          if (complete) begin
            if (complete_id == claim_id) begin
              in_service <= in_service & ~claim_mask;
              claim_id   <= '0;
              state      <= IDLE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_claim_arbiter.sv
// Directed testbench for int_claim_arbiter; honours INT_CLAIM_ARBITER_EDGE_EN.
module tb_int_claim_arbiter;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W = 2;
  localparam int ID_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_SRC-1:0] irq_in = '0;
  logic              cfg_we = 1'b0;
  logic [ID_W-1:0]   cfg_id = '0;
  logic              cfg_en = 1'b0;
  logic [PRIO_W-1:0] cfg_prio = '0;
  logic [PRIO_W-1:0] threshold = '0;
  logic              irq_req;
  logic              claim = 1'b0;
  logic [ID_W-1:0]   claim_id;
  logic              complete = 1'b0;
  logic [ID_W-1:0]   complete_id = '0;
  logic              err;

  int errors = 0;
  int checks = 0;

  int_claim_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .cfg_we     (cfg_we),
    .cfg_id     (cfg_id),
    .cfg_en     (cfg_en),
    .cfg_prio   (cfg_prio),
    .threshold  (threshold),
    .irq_req    (irq_req),
    .claim      (claim),
    .claim_id   (claim_id),
    .complete   (complete),
    .complete_id(complete_id),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cfg(input logic [ID_W-1:0] id, input logic e, input logic [PRIO_W-1:0] p);
    cfg_we = 1'b1; cfg_id = id; cfg_en = e; cfg_prio = p;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic claim_pulse();
    claim = 1'b1;
    step(1);
    claim = 1'b0;
  endtask

  task automatic complete_pulse(input logic [ID_W-1:0] id);
    complete = 1'b1; complete_id = id;
    step(1);
    complete = 1'b0;
  endtask

  task automatic wait_offer(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step(1);
      if (irq_req === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_in = 8'hFF;
    step(2);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq_req: got %b expected 0", irq_req); end
    checks++; if (claim_id !== 4'd0) begin errors++; $display("[TB] FAIL reset_claim_id: got %0d expected 0", claim_id); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    reset = 1'b1; irq_in = 8'h00;
    cfg(4'd1, 1'b1, 2'd3);
    step(5);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_pending: got %b expected 0", irq_req); end
    cfg(4'd1, 1'b0, 2'd0);
  endtask

  task automatic test_single();
    threshold = 2'd0;
    cfg(4'd3, 1'b1, 2'd2);
    irq_in = 8'h04;
    step(1);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL single_lat_e0: got %b expected 0", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL single_lat_e1: got %b expected 0", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b1) begin errors++; $display("[TB] FAIL single_lat_e2: got %b expected 1", irq_req); end
    checks++; if (claim_id !== 4'd3) begin errors++; $display("[TB] FAIL single_id: got %0d expected 3", claim_id); end
    irq_in = 8'h00;
    claim_pulse();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL single_claim_req: got %b expected 0", irq_req); end
    checks++; if (claim_id !== 4'd3) begin errors++; $display("[TB] FAIL single_service_id: got %0d expected 3", claim_id); end
    complete_pulse(4'd3);
    checks++; if (claim_id !== 4'd0) begin errors++; $display("[TB] FAIL single_complete_id: got %0d expected 0", claim_id); end
    step(4);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_req: got %b expected 0", irq_req); end
  endtask

  task automatic test_priority();
    bit seen;
    cfg(4'd2, 1'b1, 2'd1);
    cfg(4'd5, 1'b1, 2'd3);
    cfg(4'd6, 1'b1, 2'd3);
    irq_in = 8'h32;
    wait_offer(8, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL prio_offer1: got %b expected 1", seen); end
    checks++; if (claim_id !== 4'd5) begin errors++; $display("[TB] FAIL prio_first: got %0d expected 5", claim_id); end
    irq_in = 8'h22;
    claim_pulse();
    complete_pulse(4'd5);
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd6) begin errors++; $display("[TB] FAIL prio_second: got %0d expected 6", claim_id); end
    irq_in = 8'h02;
    claim_pulse();
    complete_pulse(4'd6);
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd2) begin errors++; $display("[TB] FAIL prio_third: got %0d expected 2", claim_id); end
    irq_in = 8'h00;
    claim_pulse();
    complete_pulse(4'd2);
    checks++; if (claim_id !== 4'd0) begin errors++; $display("[TB] FAIL prio_done: got %0d expected 0", claim_id); end
  endtask

  task automatic test_threshold();
    bit seen;
    cfg(4'd4, 1'b1, 2'd1);
    threshold = 2'd1;
    irq_in = 8'h08;
    step(6);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL thresh_block: got %b expected 0", irq_req); end
    threshold = 2'd0;
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd4) begin errors++; $display("[TB] FAIL thresh_offer: got %0d expected 4", claim_id); end
    cfg(4'd4, 1'b0, 2'd1);
    checks++; if (irq_req !== 1'b1) begin errors++; $display("[TB] FAIL disable_hold: got %b expected 1", irq_req); end
    step(1);
    checks++; if (claim_id !== 4'd0) begin errors++; $display("[TB] FAIL disable_withdraw_id: got %0d expected 0", claim_id); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL disable_withdraw_req: got %b expected 0", irq_req); end
    irq_in = 8'h00;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clean: got %b expected 0", err); end
  endtask

  task automatic test_errors();
    bit seen;
    irq_in = 8'h04;
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd3) begin errors++; $display("[TB] FAIL err_offer: got %0d expected 3", claim_id); end
    irq_in = 8'h00;
    claim_pulse();
    complete_pulse(4'd7);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_bad_complete: got %b expected 1", err); end
    checks++; if (claim_id !== 4'd3) begin errors++; $display("[TB] FAIL err_stay_service: got %0d expected 3", claim_id); end
    complete_pulse(4'd3);
    checks++; if (claim_id !== 4'd0) begin errors++; $display("[TB] FAIL err_good_complete: got %0d expected 0", claim_id); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_reset_clear: got %b expected 0", err); end
    claim_pulse();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_idle_claim: got %b expected 1", err); end
  endtask

`ifdef INT_CLAIM_ARBITER_EDGE_EN
  task automatic test_edge();
    bit seen;
    cfg(4'd1, 1'b1, 2'd1);
    irq_in = 8'h01;
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd1) begin errors++; $display("[TB] FAIL edge_first: got %0d expected 1", claim_id); end
    claim_pulse();
    complete_pulse(4'd1);
    step(6);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL edge_held_no_reoffer: got %b expected 0", irq_req); end
    irq_in = 8'h00;
    step(1);
    irq_in = 8'h01;
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd1) begin errors++; $display("[TB] FAIL edge_rise_offer: got %0d expected 1", claim_id); end
    claim_pulse();
    irq_in = 8'h00;
    step(1);
    irq_in = 8'h01;
    step(1);
    complete_pulse(4'd1);
    wait_offer(8, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL edge_latched_offer: got %b expected 1", seen); end
    checks++; if (claim_id !== 4'd1) begin errors++; $display("[TB] FAIL edge_latched_id: got %0d expected 1", claim_id); end
    irq_in = 8'h00;
    claim_pulse();
    complete_pulse(4'd1);
  endtask
`else
  task automatic test_back_to_back();
    bit seen;
    cfg(4'd3, 1'b1, 2'd2);
    irq_in = 8'h04;
    wait_offer(8, seen);
    checks++; if (claim_id !== 4'd3) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 3", claim_id); end
    claim_pulse();
    step(3);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_rearb: got %b expected 0", irq_req); end
    complete_pulse(4'd3);
    step(2);
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_repend_early: got %b expected 0", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_repend_offer: got %b expected 1", irq_req); end
    checks++; if (claim_id !== 4'd3) begin errors++; $display("[TB] FAIL b2b_repend_id: got %0d expected 3", claim_id); end
    irq_in = 8'h00;
    claim_pulse();
    complete_pulse(4'd3);
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_priority();
    test_threshold();
    test_errors();
    cfg(4'd3, 1'b1, 2'd2);
`ifdef INT_CLAIM_ARBITER_EDGE_EN
    test_edge();
`else
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
